// File: rtl/rr_or_arbiter_pkg.sv
// Shared types and defaults for the round-robin OR-resource arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned ARB_DEFAULT_N        = 4;
    localparam int unsigned ARB_DEFAULT_MAX_HOLD = 4;

endpackage

// File: rtl/rr_or_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_or_arbiter_if
    import arb_pkg::*;
#(
    parameter int unsigned N = ARB_DEFAULT_N
);
    localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_valid;
    logic            any_req;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  any_req
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output any_req
    );

endinterface

// File: rtl/rr_or_arbiter_pick.sv
// Circular priority search: first set request at or after 'start', wrapping to 0.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned N = ARB_DEFAULT_N,
    localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] start,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    logic [N-1:0]    rot;
    logic [ID_W-1:0] off;

    // Rotate so 'start' lands at bit 0, priority-encode, then rotate the index back.
    always_comb begin
        rot   = '0;
        found = 1'b0;
        off   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rot[i] = req[(i + 32'(start)) % N];
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = ID_W'(i);
            end
        end
        idx = ID_W'((32'(off) + 32'(start)) % N);
    end

endmodule

// File: rtl/rr_or_arbiter.sv
// Round-robin arbiter granting one requester at a time ownership of a shared
// OR-combined resource, with optional per-owner hold limit.
module rr_or_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N        = ARB_DEFAULT_N,
    parameter int unsigned MAX_HOLD = ARB_DEFAULT_MAX_HOLD
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_or_arbiter_if.slave bus
);

    localparam int unsigned ID_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic            gnt_valid_q;

    logic [ID_W-1:0] next_owner;
    logic [ID_W-1:0] search_start;
    logic [ID_W-1:0] pick_idx;
    logic            pick_found;
    logic            owner_req;
    logic            timeout;

    assign bus.any_req   = |bus.req;
    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;

    assign next_owner   = (gnt_id_q == ID_W'(N - 1)) ? '0 : gnt_id_q + 1'b1;
    assign owner_req    = bus.req[gnt_id_q];
    assign timeout      = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    // Re-arbitration searches from the slot after the owner, so a timed-out
    // owner is only regranted when nobody else is asking.
    assign search_start = (state_q == IDLE) ? ptr_q : next_owner;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req   (bus.req),
        .start (search_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d         = GRANT;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gnt_id_d        = pick_idx;
                    hold_d          = '0;
                end
            end
            GRANT: begin
                if (owner_req && !timeout) begin
                    if (hold_q != '1) begin
                        hold_d = hold_q + 1'b1;
                    end
                end else begin
                    ptr_d  = next_owner;
                    hold_d = '0;
                    if (pick_found) begin
                        gnt_d           = '0;
                        gnt_d[pick_idx] = 1'b1;
                        gnt_id_d        = pick_idx;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                hold_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_q      <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= |gnt_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(gnt_q));
            assert (gnt_valid_q == |gnt_q);
            assert (gnt_q[gnt_id_q] == gnt_valid_q);
            assert ((state_q == GRANT) == gnt_valid_q);
        end
    end
`endif

endmodule

// File: tb/tb_rr_or_arbiter.sv
// Directed bench for rr_or_arbiter: one instance with MAX_HOLD=4, one unlimited.
module tb_rr_or_arbiter;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        string      name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    rr_or_arbiter_if #(.N(4)) if4 ();
    rr_or_arbiter_if #(.N(4)) if0 ();

    rr_or_arbiter #(.N(4), .MAX_HOLD(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    rr_or_arbiter #(.N(4), .MAX_HOLD(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Drive req on the falling edge, check registered outputs just after the rising edge.
    task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] eid, input string nm);
        @(negedge clk);
        if4.req = r;
        @(posedge clk);
        #1;
        check({nm, ".gnt"}, 32'(if4.gnt), 32'(eg));
        check({nm, ".gnt_id"}, 32'(if4.gnt_id), 32'(eid));
        check({nm, ".gnt_valid"}, 32'(if4.gnt_valid), 32'(|eg));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        if4.req = '0;
        if0.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[12];
    logic [3:0] rot_req[8];
    logic [3:0] rot_gnt[8];

    initial begin
        n_pass  = 0;
        n_total = 0;

        tbl[0]  = '{4'b0100, 4'b0100, 2'd2, "single_grant"};
        tbl[1]  = '{4'b0100, 4'b0100, 2'd2, "single_hold"};
        tbl[2]  = '{4'b0000, 4'b0000, 2'd0, "single_release"};
        tbl[3]  = '{4'b0011, 4'b0001, 2'd0, "idle_wrap_pick"};
        tbl[4]  = '{4'b0011, 4'b0001, 2'd0, "owner0_hold"};
        tbl[5]  = '{4'b0010, 4'b0010, 2'd1, "handover_0_to_1"};
        tbl[6]  = '{4'b1010, 4'b0010, 2'd1, "other_req_ignored"};
        tbl[7]  = '{4'b1010, 4'b0010, 2'd1, "owner1_hold2"};
        tbl[8]  = '{4'b1010, 4'b0010, 2'd1, "owner1_hold3"};
        tbl[9]  = '{4'b1010, 4'b1000, 2'd3, "timeout_to_3"};
        tbl[10] = '{4'b0010, 4'b0010, 2'd1, "release_wrap_to_1"};
        tbl[11] = '{4'b0000, 4'b0000, 2'd0, "release_to_idle"};

        rot_req = '{4'b0101, 4'b0101, 4'b0100, 4'b0101, 4'b0001, 4'b0101, 4'b0100, 4'b0101};
        rot_gnt = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0100, 4'b0100};

        // Reset held with all requests active
        rst_n   = 1'b0;
        if4.req = 4'b1111;
        if0.req = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check("reset.gnt", 32'(if4.gnt), 32'h0);
        check("reset.gnt_id", 32'(if4.gnt_id), 32'h0);
        check("reset.gnt_valid", 32'(if4.gnt_valid), 32'h0);
        check("reset.any_req", 32'(if4.any_req), 32'h1);
        check("reset.unl_gnt", 32'(if0.gnt), 32'h0);
        @(negedge clk);
        if4.req = '0;
        if0.req = '0;
        rst_n   = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].req, tbl[i].gnt, tbl[i].id, tbl[i].name);
            check({tbl[i].name, ".any_req"}, 32'(if4.any_req), 32'(|tbl[i].req));
        end

        // Asynchronous reset between edges while a grant is held
        step(4'b0100, 4'b0100, 2'd2, "pre_async_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.gnt", 32'(if4.gnt), 32'h0);
        check("async_rst.gnt_valid", 32'(if4.gnt_valid), 32'h0);
        @(negedge clk);
        if4.req = '0;
        rst_n   = 1'b1;

        // All requesting: each owner times out after 4 cycles, no idle gap
        for (int c = 0; c < 20; c++) begin
            step(4'b1111, 4'(4'b0001 << ((c / 4) % 4)), 2'((c / 4) % 4), $sformatf("saturate_c%0d", c));
        end

        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(rot_req[i], rot_gnt[i], (rot_gnt[i] == 4'b0100) ? 2'd2 : 2'd0, $sformatf("rotate_s%0d", i));
        end

        // Sole requester keeps the grant across its own timeouts
        for (int c = 0; c < 12; c++) begin
            step(4'b0010, 4'b0010, 2'd1, $sformatf("sole_c%0d", c));
        end

        // Reset while owner 3 holds; arbitration restarts from slot 0
        step(4'b1000, 4'b1000, 2'd3, "owner3_before_rst");
        #2;
        rst_n   = 1'b0;
        if4.req = 4'b1111;
        if0.req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart.gnt", 32'(if4.gnt), 32'h1);
        check("restart.gnt_id", 32'(if4.gnt_id), 32'h0);
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("unlimited_c%0d.gnt", c), 32'(if0.gnt), 32'h1);
        end
        check("unlimited.gnt_id", 32'(if0.gnt_id), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
